issue_scheduler: RTL and testbench

Issue scheduler for the out-of-order back end: it sits between the four reservation queues (integer, load/store, multiply, divide) filled by the dispatcher and their functional units. Each cycle it grants queue heads whose operands are ready, guarantees that no two results ever collide on the single common data bus (CDB), and tracks the non-pipelined divider. It publishes which unit owns the CDB in every cycle.

---
 rtl/issue_scheduler_pkg.sv | 18 +
 rtl/issue_scheduler_reservation_reg.sv | 66 ++++++
 rtl/issue_scheduler.sv | 90 +++++++++
 tb/tb_issue_scheduler.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/issue_scheduler_pkg.sv
// Shared definitions for the issue scheduler, CDB mux and functional units.
// Holds the functional-unit identifiers and the default unit latencies.
// No logic; types and constants only.
package issue_scheduler_pkg;

  typedef enum logic [1:0] {
    FU_INT  = 2'd0,
    FU_LS   = 2'd1,
    FU_MULT = 2'd2,
    FU_DIV  = 2'd3
  } fu_id_t;

  localparam int DEF_INT_LAT  = 1;
  localparam int DEF_LS_LAT   = 1;
  localparam int DEF_MULT_LAT = 4;
  localparam int DEF_DIV_LAT  = 7;  // must stay the largest latency

endpackage

// File: rtl/issue_scheduler_reservation_reg.sv
// CDB reservation vector: entry k describes the CDB k cycles from now.
// Latency: writes visible next cycle, already shifted by one slot; taps are combinational.
// Backpressure: none; callers only write slots they have checked are free.
module issue_scheduler_reservation_reg
  import issue_scheduler_pkg::*;
#(
  parameter int INT_LAT  = DEF_INT_LAT,
  parameter int LS_LAT   = DEF_LS_LAT,
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT,
  localparam int IW      = $clog2(DIV_LAT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  // latency-1 pair (integer or load/store) share one write port
  input  logic          set_pair_vld,
  input  logic [IW-1:0] set_pair_idx,
  input  fu_id_t        set_pair_id,
  input  logic          set_mult_vld,
  input  logic          set_div_vld,
  output logic          slot_int,
  output logic          slot_ls,
  output logic          slot_mult,
  output logic          slot_div,
  output logic          head_vld,
  output fu_id_t        head_id
);

  logic [DIV_LAT:0] vld_q;
  fu_id_t           id_q [DIV_LAT+1];

  // Shift toward slot 0 every cycle, then apply this cycle's reservations.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q <= '0;
      for (int k = 0; k <= DIV_LAT; k++) id_q[k] <= FU_INT;
    end else begin
      for (int k = 0; k < DIV_LAT; k++) begin
        vld_q[k] <= vld_q[k+1];
        id_q[k]  <= id_q[k+1];
      end
      vld_q[DIV_LAT] <= 1'b0;
      id_q[DIV_LAT]  <= FU_INT;
      if (set_pair_vld) begin
        vld_q[set_pair_idx] <= 1'b1;
        id_q[set_pair_idx]  <= set_pair_id;
      end
      if (set_mult_vld) begin
        vld_q[MULT_LAT-1] <= 1'b1;
        id_q[MULT_LAT-1]  <= FU_MULT;
      end
      if (set_div_vld) begin
        vld_q[DIV_LAT-1] <= 1'b1;
        id_q[DIV_LAT-1]  <= FU_DIV;
      end
    end
  end

  assign slot_int  = vld_q[INT_LAT];
  assign slot_ls   = vld_q[LS_LAT];
  assign slot_mult = vld_q[MULT_LAT];
  assign slot_div  = vld_q[DIV_LAT];
  assign head_vld  = vld_q[0];
  assign head_id   = id_q[0];

endmodule

// File: rtl/issue_scheduler.sv
// Grants ready queue heads so that results never collide on the single CDB.
// Latency: grants are combinational in the same cycle; results appear LAT cycles later.
// Backpressure: a unit whose CDB slot is taken (or divider busy, or stall) simply waits.
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter int INT_LAT  = DEF_INT_LAT,
  parameter int LS_LAT   = DEF_LS_LAT,
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   ready_int,
  input  logic   ready_ls,
  input  logic   ready_mult,
  input  logic   ready_div,
  input  logic   stall_issue,
  output logic   issue_int,
  output logic   issue_ls,
  output logic   issue_mult,
  output logic   issue_div,
  output logic   div_busy,
  output logic   cdb_valid,
  output fu_id_t cdb_owner
);

  localparam int IW = $clog2(DIV_LAT + 1);
  localparam int CW = $clog2(DIV_LAT + 1);

  logic          slot_int, slot_ls, slot_mult, slot_div;
  logic          elig_int, elig_ls, elig_mult, elig_div;
  logic          can_issue;
  logic          contended;
  logic          rr_ls;      // 0: integer wins next contention, 1: load/store wins
  logic [CW-1:0] div_cnt;
  logic [IW-1:0] pair_idx;

  issue_scheduler_reservation_reg #(
    .INT_LAT  (INT_LAT),
    .LS_LAT   (LS_LAT),
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_resv (
    .clk          (clk),
    .rst          (rst),
    .set_pair_vld (issue_int | issue_ls),
    .set_pair_idx (pair_idx),
    .set_pair_id  (issue_ls ? FU_LS : FU_INT),
    .set_mult_vld (issue_mult),
    .set_div_vld  (issue_div),
    .slot_int     (slot_int),
    .slot_ls      (slot_ls),
    .slot_mult    (slot_mult),
    .slot_div     (slot_div),
    .head_vld     (cdb_valid),
    .head_id      (cdb_owner)
  );

  assign div_busy = (div_cnt != '0);

  // Eligibility and grants; integer and load/store contend for the same slot.
  always_comb begin
    can_issue  = !stall_issue && !rst;
    elig_int   = ready_int  && can_issue && !slot_int;
    elig_ls    = ready_ls   && can_issue && !slot_ls;
    elig_mult  = ready_mult && can_issue && !slot_mult;
    elig_div   = ready_div  && can_issue && !slot_div && !div_busy;
    contended  = elig_int && elig_ls;
    issue_int  = elig_int && (!elig_ls || !rr_ls);
    issue_ls   = elig_ls  && (!elig_int || rr_ls);
    issue_mult = elig_mult;
    issue_div  = elig_div;
    pair_idx   = issue_ls ? IW'(LS_LAT - 1) : IW'(INT_LAT - 1);
  end

  // Round-robin pointer only moves when both latency-1 units actually competed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ls <= 1'b0;
    else if (contended) rr_ls <= !rr_ls;
  end

  // Divider occupancy: counts down the cycles until the next divide may start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) div_cnt <= '0;
    else if (issue_div) div_cnt <= CW'(DIV_LAT - 1);
    else if (div_cnt != '0) div_cnt <= div_cnt - 1'b1;
  end

endmodule

// File: tb/tb_issue_scheduler.sv
// Self-checking bench for issue_scheduler: directed scenarios plus random traffic.
// Reference model books CDB usage in a map keyed by absolute cycle number.
module tb_issue_scheduler;
  import issue_scheduler_pkg::*;

  localparam int INT_LAT  = 1;
  localparam int LS_LAT   = 1;
  localparam int MULT_LAT = 4;
  localparam int DIV_LAT  = 7;

  logic   clk = 1'b0;
  logic   rst = 1'b1;
  logic   ready_int = 1'b0, ready_ls = 1'b0, ready_mult = 1'b0, ready_div = 1'b0;
  logic   stall_issue = 1'b0;
  logic   issue_int, issue_ls, issue_mult, issue_div;
  logic   div_busy, cdb_valid;
  fu_id_t cdb_owner;

  issue_scheduler #(
    .INT_LAT(INT_LAT), .LS_LAT(LS_LAT), .MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .ready_int(ready_int), .ready_ls(ready_ls), .ready_mult(ready_mult), .ready_div(ready_div),
    .stall_issue(stall_issue),
    .issue_int(issue_int), .issue_ls(issue_ls), .issue_mult(issue_mult), .issue_div(issue_div),
    .div_busy(div_busy), .cdb_valid(cdb_valid), .cdb_owner(cdb_owner)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // model state: CDB bookings by absolute cycle, last divide start, RR preference
  int cyc      = 0;
  int sched [int];
  int div_last = -1000;
  bit rr_ls    = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input bit ri, input bit rl, input bit rm, input bit rd,
                      input bit st, input bit rs);
    bit base, e_int, e_ls, e_m, e_d, busy, g_int, g_ls, exp_v;
    @(negedge clk);
    ready_int = ri; ready_ls = rl; ready_mult = rm; ready_div = rd;
    stall_issue = st; rst = rs;
    #1;
    if (rs) begin
      sched.delete();
      div_last = -1000;
      rr_ls = 1'b0;
    end
    busy  = (cyc - div_last >= 1) && (cyc - div_last <= DIV_LAT - 1);
    base  = !st && !rs;
    e_int = ri && base && !sched.exists(cyc + INT_LAT);
    e_ls  = rl && base && !sched.exists(cyc + LS_LAT);
    e_m   = rm && base && !sched.exists(cyc + MULT_LAT);
    e_d   = rd && base && !sched.exists(cyc + DIV_LAT) && !busy;
    g_int = e_int && (!e_ls || !rr_ls);
    g_ls  = e_ls && (!e_int || rr_ls);
    exp_v = sched.exists(cyc);

    chk("issue_int",  32'(issue_int),  32'(g_int));
    chk("issue_ls",   32'(issue_ls),   32'(g_ls));
    chk("issue_mult", 32'(issue_mult), 32'(e_m));
    chk("issue_div",  32'(issue_div),  32'(e_d));
    chk("div_busy",   32'(div_busy),   32'(busy));
    chk("cdb_valid",  32'(cdb_valid),  32'(exp_v));
    if (exp_v)   chk("cdb_owner", 32'(cdb_owner), 32'(sched[cyc]));
    else if (rs) chk("cdb_owner_rst", 32'(cdb_owner), 32'(FU_INT));

    if (e_int && e_ls) rr_ls = !rr_ls;
    if (g_int) sched[cyc + INT_LAT]  = int'(FU_INT);
    if (g_ls)  sched[cyc + LS_LAT]   = int'(FU_LS);
    if (e_m)   sched[cyc + MULT_LAT] = int'(FU_MULT);
    if (e_d) begin
      sched[cyc + DIV_LAT] = int'(FU_DIV);
      div_last = cyc;
    end
    if (sched.exists(cyc)) sched.delete(cyc);
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // reset held, then idle
    step(0, 0, 0, 0, 0, 1);
    step(1, 1, 1, 1, 0, 1);
    idle(3);

    // int and ls contend for four cycles: alternating grants
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 0);
    idle(3);

    // mult at t0, int held from t3: int blocked at t3, granted at t4
    step(0, 0, 1, 0, 0, 0);
    idle(2);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    idle(4);

    // back-to-back divides with ready_div held
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1, 0, 0);
    idle(9);

    // div at t0, mult held from t3: mult blocked at t3, granted at t4
    step(0, 0, 0, 1, 0, 0);
    idle(2);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    idle(8);

    // everything ready, then stall three cycles: reservations still drain
    step(1, 1, 1, 1, 0, 0);
    step(1, 1, 1, 1, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 1, 1, 1, 1, 0);
    idle(8);

    // reset with a mult in flight: the result must never reach the CDB
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    idle(6);

    // random traffic with occasional stalls and resets
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 127) == 0));
    end
    idle(10);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
